// File: rtl/panel_pkg.sv
// Shared types and default constants for the front-panel clock controller.
// Contents: controller state enum and power-on default parameter values.
package panel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    USTEP = 2'd1,
    ISTEP = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam logic [15:0]  DEF_DEB_CYCLES       = 16'd50000;
  localparam logic [15:0]  DEF_RUN_DIV          = 16'd4;
  localparam int unsigned  DEF_PULSES_PER_USTEP = 2;
  localparam logic [7:0]   DEF_FETCH_UADDR      = 8'h00;
  localparam logic [7:0]   DEF_MAX_USTEPS       = 8'd64;

endpackage

// File: rtl/debounce.sv
// Two-flop synchroniser followed by a stability counter for one raw input.
// Ports: clk, clr (async active-high reset), din (raw input),
//        level (debounced level), rise (1-cycle pulse on debounced rising edge).
module debounce #(
  parameter int unsigned WIDTH_CNT = 16,
  parameter int unsigned CYCLES    = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam logic [WIDTH_CNT-1:0] LAST = WIDTH_CNT'(CYCLES - 1);

  logic [1:0]           sync;
  logic [WIDTH_CNT-1:0] cnt;

  // Level follows the synchronised input only after CYCLES consecutive differing cycles.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync  <= 2'b00;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      rise <= 1'b0;
      if (sync[1] != level) begin
        if (cnt == LAST) begin
          level <= sync[1];
          rise  <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + WIDTH_CNT'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/step_clk_ctrl.sv
// Front-panel clock controller: gates board-clock pulses onto the CPU clock
// in free-run, single micro-step or single instruction-step modes.
// Ports: clk (board clock), clr (async active-high reset), run_sw, step_btn,
//        step_mode (0 micro-step / 1 instruction-step), uaddr (CPU micro-address),
//        cpu_clk (CPU clock), busy, ustep_cnt (completed micro-steps),
//        timeout (sticky instruction-step abort flag).
module step_clk_ctrl
  import panel_pkg::*;
#(
  parameter logic [15:0] DEB_CYCLES       = DEF_DEB_CYCLES,
  parameter logic [15:0] RUN_DIV          = DEF_RUN_DIV,
  parameter int unsigned PULSES_PER_USTEP = DEF_PULSES_PER_USTEP,
  parameter logic [7:0]  FETCH_UADDR      = DEF_FETCH_UADDR,
  parameter logic [7:0]  MAX_USTEPS       = DEF_MAX_USTEPS
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        step_mode,
  input  logic [7:0]  uaddr,
  output logic        cpu_clk,
  output logic        busy,
  output logic [15:0] ustep_cnt,
  output logic        timeout
);

  localparam logic [7:0] LAST_PULSE = 8'(PULSES_PER_USTEP - 1);

  logic run_lvl, run_rise;
  logic step_lvl, step_req;

  debounce #(.WIDTH_CNT(16), .CYCLES(32'(DEB_CYCLES))) u_deb_run (
    .clk(clk), .clr(clr), .din(run_sw), .level(run_lvl), .rise(run_rise)
  );

  debounce #(.WIDTH_CNT(16), .CYCLES(32'(DEB_CYCLES))) u_deb_step (
    .clk(clk), .clr(clr), .din(step_btn), .level(step_lvl), .rise(step_req)
  );

  // Only the run level and the step rising edge drive the controller.
  logic unused_deb;
  assign unused_deb = &{1'b0, run_rise, step_lvl};

  state_t      state;
  logic [15:0] div;
  logic [7:0]  pcnt;
  logic [7:0]  isteps;
  logic        pend;
  logic        done1;
  logic        ustep_done;
  logic        tick;

  assign tick = (div == RUN_DIV - 16'd1);

  // Pulse engine and mode FSM. pend is cleared after the last pulse of a
  // micro-step and only re-armed by the FSM once ustep_done is evaluated,
  // so a decision to stop always lands on a micro-step boundary.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      div        <= '0;
      pcnt       <= '0;
      isteps     <= '0;
      pend       <= 1'b0;
      done1      <= 1'b0;
      ustep_done <= 1'b0;
      cpu_clk    <= 1'b0;
      busy       <= 1'b0;
      ustep_cnt  <= '0;
      timeout    <= 1'b0;
    end else begin
      cpu_clk    <= 1'b0;
      done1      <= 1'b0;
      ustep_done <= done1;
      if (ustep_done) ustep_cnt <= ustep_cnt + 16'd1;

      if (state == IDLE) div <= '0;
      else               div <= tick ? '0 : div + 16'd1;

      if (state != IDLE && tick && pend) begin
        cpu_clk <= 1'b1;
        if (pcnt == LAST_PULSE) begin
          pcnt  <= '0;
          pend  <= 1'b0;
          done1 <= 1'b1;
        end else begin
          pcnt <= pcnt + 8'd1;
        end
      end

      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (run_lvl || step_req) begin
            pend   <= 1'b1;
            pcnt   <= '0;
            isteps <= '0;
            busy   <= 1'b1;
            if (run_lvl)        state <= RUN;
            else if (step_mode) state <= ISTEP;
            else                state <= USTEP;
          end
        end
        USTEP: begin
          if (ustep_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ISTEP: begin
          if (ustep_done) begin
            isteps <= isteps + 8'd1;
            if (uaddr == FETCH_UADDR) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (isteps + 8'd1 == MAX_USTEPS) begin
              timeout <= 1'b1;
              state   <= IDLE;
              busy    <= 1'b0;
            end else begin
              pend <= 1'b1;
            end
          end
        end
        RUN: begin
          if (ustep_done) begin
            if (!run_lvl) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              pend <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_clk_ctrl.sv
// Directed testbench for step_clk_ctrl with a small CPU micro-address model
// and an expected-value queue popped when DUT results are observed.
module tb_step_clk_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        run_sw;
  logic        step_btn;
  logic        step_mode;
  logic [7:0]  uaddr;
  logic        cpu_clk;
  logic        busy;
  logic [15:0] ustep_cnt;
  logic        timeout;

  step_clk_ctrl #(
    .DEB_CYCLES(16'd4), .RUN_DIV(16'd4), .PULSES_PER_USTEP(2),
    .FETCH_UADDR(8'h00), .MAX_USTEPS(8'd8)
  ) dut (
    .clk(clk), .clr(clr), .run_sw(run_sw), .step_btn(step_btn),
    .step_mode(step_mode), .uaddr(uaddr), .cpu_clk(cpu_clk), .busy(busy),
    .ustep_cnt(ustep_cnt), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: cpu_clk is high for exactly one board cycle per pulse.
  int pulse_count = 0;
  int pulse_cyc[$];
  always @(negedge clk) begin
    if (cpu_clk === 1'b1) begin
      pulse_count = pulse_count + 1;
      pulse_cyc.push_back(cyc);
    end
  end

  // CPU micro-address model: mode 1 walks 00 -> 10 -> 11 -> 00 per micro-step.
  int         ua_mode  = 0;
  logic [7:0] ua_const = 8'h00;
  int         ua_base  = 0;
  always_comb begin
    int k;
    k = (pulse_count - ua_base) / 2;
    uaddr = ua_const;
    if (ua_mode == 1) begin
      case (k)
        1:       uaddr = 8'h10;
        2:       uaddr = 8'h11;
        default: uaddr = 8'h00;
      endcase
    end
  end

  typedef struct {
    string tag;
    int    val;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  task automatic push_exp(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input int obs);
    exp_t e;
    tests++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL scoreboard_empty: observed %0d required none", obs);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s: observed %0d required %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic wait_busy(input logic v, input int budget, input string tag);
    int n;
    n = 0;
    while (busy !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    assert (busy === v) else begin
      fails++;
      $error("FAIL %s: observed busy=%b required %b", tag, busy, v);
    end
  endtask

  task automatic wait_pulses(input int base, input int num, input int budget);
    int n;
    n = 0;
    while (pulse_count - base < num && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  task automatic press_step(input int budget, input string tag);
    step_btn = 1'b1;
    wait_busy(1'b1, 30, {tag, "_busy_rise"});
    wait_busy(1'b0, budget, {tag, "_busy_fall"});
    step_btn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  logic [15:0] uc;
  int base, base2, delta;

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish required finish");
    $fatal(1);
  end

  initial begin
    clr = 1'b1; run_sw = 1'b0; step_btn = 1'b0; step_mode = 1'b0;
    uc = 16'd0;
    repeat (3) @(negedge clk);
    push_exp("rst_cpu_clk", 0);   check(int'(cpu_clk));
    push_exp("rst_busy", 0);      check(int'(busy));
    push_exp("rst_ustep_cnt", 0); check(int'(ustep_cnt));
    push_exp("rst_timeout", 0);   check(int'(timeout));
    clr = 1'b0;
    repeat (3) @(negedge clk);

    // 1: reset asserted while cpu_clk is high during a run.
    base = pulse_count;
    run_sw = 1'b1;
    push_exp("t1_third_pulse", 1);
    push_exp("t1_cpu_clk_high", 1);
    push_exp("t1_ustep_before", 1);
    wait_pulses(base, 3, 100);
    check(int'(pulse_count - base >= 3));
    check(int'(cpu_clk));
    check(int'(ustep_cnt));
    clr = 1'b1; run_sw = 1'b0;
    #1;
    push_exp("t1_cpu_clk", 0);   check(int'(cpu_clk));
    push_exp("t1_busy", 0);      check(int'(busy));
    push_exp("t1_ustep_cnt", 0); check(int'(ustep_cnt));
    push_exp("t1_timeout", 0);   check(int'(timeout));
    uc = 16'd0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    base = pulse_count;
    repeat (30) @(negedge clk);
    push_exp("t1_no_pulses", 0); check(pulse_count - base);

    // 2: bouncing step button, then a clean press -> one micro-step.
    step_mode = 1'b0;
    base = pulse_count;
    for (int i = 0; i < 10; i++) begin
      step_btn = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    push_exp("t2_pulses", 2);
    push_exp("t2_spacing", 4);
    push_exp("t2_ustep_cnt", int'(uc + 16'd1));
    press_step(60, "t2");
    check(pulse_count - base);
    if (pulse_cyc.size() >= 2)
      check(pulse_cyc[pulse_cyc.size()-1] - pulse_cyc[pulse_cyc.size()-2]);
    else
      check(-1);
    uc = uc + 16'd1;
    check(int'(ustep_cnt));

    // 3: instruction step ends when the model returns to the fetch address.
    step_mode = 1'b1;
    ua_mode = 1;
    ua_base = pulse_count;
    base = pulse_count;
    push_exp("t3_pulses", 6);
    push_exp("t3_ustep_cnt", int'(uc + 16'd3));
    push_exp("t3_timeout", 0);
    press_step(200, "t3");
    check(pulse_count - base);
    uc = uc + 16'd3;
    check(int'(ustep_cnt));
    check(int'(timeout));

    // 4: instruction step aborted by the micro-step limit; timeout is sticky.
    ua_mode = 0;
    ua_const = 8'h20;
    base = pulse_count;
    push_exp("t4_pulses", 16);
    push_exp("t4_ustep_cnt", int'(uc + 16'd8));
    push_exp("t4_timeout", 1);
    press_step(200, "t4");
    check(pulse_count - base);
    uc = uc + 16'd8;
    check(int'(ustep_cnt));
    check(int'(timeout));
    base = pulse_count;
    push_exp("t4b_pulses", 16);
    push_exp("t4b_timeout", 1);
    press_step(200, "t4b");
    check(pulse_count - base);
    uc = uc + 16'd8;
    check(int'(timeout));
    ua_const = 8'h00;
    step_mode = 1'b0;

    // 5: run stop. Releasing the switch on pulse 2 makes the debounced
    // level fall just after pulse 3, i.e. inside the second micro-step.
    base = pulse_count;
    run_sw = 1'b1;
    push_exp("t5_pulses", 4);
    push_exp("t5_ustep_cnt", int'(uc + 16'd2));
    wait_pulses(base, 2, 100);
    run_sw = 1'b0;
    wait_busy(1'b0, 100, "t5_busy_fall");
    repeat (20) @(negedge clk);
    check(pulse_count - base);
    uc = uc + 16'd2;
    check(int'(ustep_cnt));

    // 6a: a step request during run is ignored, not queued.
    base = pulse_count;
    run_sw = 1'b1;
    wait_busy(1'b1, 30, "t6a_busy_rise");
    wait_pulses(base, 3, 100);
    step_btn = 1'b1;
    repeat (12) @(negedge clk);
    run_sw = 1'b0;
    wait_busy(1'b0, 100, "t6a_busy_fall");
    base2 = pulse_count;
    delta = base2 - base;
    push_exp("t6a_even_pulses", 0); check(delta % 2);
    uc = uc + 16'(delta / 2);
    repeat (30) @(negedge clk);
    push_exp("t6a_no_queued_step", 0); check(pulse_count - base2);
    step_btn = 1'b0;
    repeat (12) @(negedge clk);

    // 6b: run and step rising together -> run wins.
    base = pulse_count;
    run_sw = 1'b1;
    step_btn = 1'b1;
    repeat (40) @(negedge clk);
    push_exp("t6b_run_entered", 1); check(int'(pulse_count - base > 2));
    run_sw = 1'b0;
    step_btn = 1'b0;
    wait_busy(1'b0, 100, "t6b_busy_fall");
    repeat (12) @(negedge clk);
    delta = pulse_count - base;
    push_exp("t6b_even_pulses", 0); check(delta % 2);
    uc = uc + 16'(delta / 2);
    push_exp("final_ustep_cnt", int'(uc)); check(int'(ustep_cnt));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
